// File: rtl/keypad_pkg.sv
// Shared state encoding, key map and idle column constant for the keypad emulator.
// KEYPAD_EMU_BOUNCE_EN adds the BOUNCE state to the FSM encoding.
package keypad_pkg;

  localparam logic [3:0] COL_IDLE = 4'b1111;

`ifdef KEYPAD_EMU_BOUNCE_EN
  typedef enum logic [1:0] {IDLE, BOUNCE, PRESS, GAP} emu_state_t;
`else
  typedef enum logic [1:0] {IDLE, PRESS, GAP} emu_state_t;
`endif

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } key_pos_t;

  function automatic key_pos_t key_map(input logic [3:0] code);
    key_pos_t p;
    p = '{row: COL_IDLE, col: COL_IDLE};
    case (code)
      4'h0: p = '{row: 4'b1110, col: 4'b0111};
      4'h1: p = '{row: 4'b1110, col: 4'b1011};
      4'h2: p = '{row: 4'b1101, col: 4'b1011};
      4'h3: p = '{row: 4'b1011, col: 4'b1011};
      4'h4: p = '{row: 4'b1110, col: 4'b1101};
      4'h5: p = '{row: 4'b1101, col: 4'b1101};
      4'h6: p = '{row: 4'b1011, col: 4'b1101};
      4'h7: p = '{row: 4'b1110, col: 4'b1110};
      4'h8: p = '{row: 4'b1101, col: 4'b1110};
      4'h9: p = '{row: 4'b1011, col: 4'b1110};
      4'hA: p = '{row: 4'b1101, col: 4'b0111};
      4'hB: p = '{row: 4'b1011, col: 4'b0111};
      4'hC: p = '{row: 4'b0111, col: 4'b1110};
      4'hD: p = '{row: 4'b0111, col: 4'b1101};
      4'hE: p = '{row: 4'b0111, col: 4'b1011};
      4'hF: p = '{row: 4'b0111, col: 4'b0111};
      default: p = '{row: COL_IDLE, col: COL_IDLE};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Scanner-facing and host-facing signals of the keypad emulator.
// master = scanner/host side, slave = emulator.
interface keypad_emulator_if #(
  parameter int unsigned DEPTH = 4
);
  logic [3:0]             keyrow;
  logic                   key_valid;
  logic [3:0]             key_code;
  logic                   key_ready;
  logic [3:0]             keycol;
  logic                   busy;
  logic                   done;
  logic [$clog2(DEPTH):0] level;

  modport master (
    output keyrow, key_valid, key_code,
    input  key_ready, keycol, busy, done, level
  );

  modport slave (
    input  keyrow, key_valid, key_code,
    output key_ready, keycol, busy, done, level
  );
endinterface

// File: rtl/key_fifo.sv
// Synchronous key-code FIFO with occupancy count; push when full and pop when
// empty are ignored.
module key_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [3:0]             wdata,
  input  logic                   pop,
  output logic [3:0]             rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end
endmodule

// File: rtl/keypad_emulator.sv
// Device side of a 4x4 row-scan keypad: presses queued key codes by answering
// the scanner's row drive. KEYPAD_EMU_BOUNCE_EN enables a contact-bounce phase.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned HOLD_MATCHES   = 8,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned BOUNCE_MATCHES = 4
) (
  input logic             clock,
  input logic             reset,
  keypad_emulator_if.slave bus
);
  localparam int unsigned HG_MAX  = (HOLD_MATCHES > GAP_CYCLES) ? HOLD_MATCHES : GAP_CYCLES;
  localparam int unsigned CNT_MAX = (HG_MAX > BOUNCE_MATCHES) ? HG_MAX : BOUNCE_MATCHES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MATCHES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [CW-1:0] BOUNCE_LAST = CW'(BOUNCE_MATCHES - 1);
`endif

  emu_state_t state;
  logic [CW-1:0] cnt;
  logic [3:0]    trow;
  logic [3:0]    tcol;
  logic          done_q;
  logic          row_hit;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [3:0]    fifo_rdata;
  key_pos_t      head;

  key_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.key_valid),
    .wdata (bus.key_code),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (bus.level)
  );

  assign head          = key_map(fifo_rdata);
  assign fifo_pop      = (state == IDLE) && !fifo_empty;
  assign row_hit       = (bus.keyrow == trow);
  assign bus.key_ready = !fifo_full;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

  // Zero-latency column return: a scanner sampling on posedge sees the press.
  always_comb begin
    bus.keycol = COL_IDLE;
    if (state == PRESS && row_hit) bus.keycol = tcol;
`ifdef KEYPAD_EMU_BOUNCE_EN
    if (state == BOUNCE && row_hit && cnt[0]) bus.keycol = tcol;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      trow   <= COL_IDLE;
      tcol   <= COL_IDLE;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            trow <= head.row;
            tcol <= head.col;
            cnt  <= '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            state <= BOUNCE;
`else
            state <= PRESS;
`endif
          end
        end
`ifdef KEYPAD_EMU_BOUNCE_EN
        BOUNCE: begin
          if (row_hit) begin
            if (cnt == BOUNCE_LAST) begin
              cnt   <= '0;
              state <= PRESS;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`endif
        PRESS: begin
          if (row_hit) begin
            if (cnt == HOLD_LAST) begin
              cnt    <= '0;
              state  <= GAP;
              done_q <= (GAP_CYCLES == 1);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        GAP: begin
          // done is registered, so it is raised on entry to the last gap cycle.
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt    <= cnt + 1'b1;
            done_q <= ((cnt + 1'b1) == GAP_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_emulator.sv
// Directed self-checking bench for keypad_emulator (default build or with
// KEYPAD_EMU_BOUNCE_EN defined).
module tb_keypad_emulator;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned HOLD   = 8;
  localparam int unsigned GAP    = 16;
  localparam int unsigned BOUNCE = 4;

  logic clock;
  logic reset;
  int unsigned vectors;
  int unsigned miscompares;
  int unsigned rot;
  logic [3:0] rows [4];
  logic [3:0] burst [4];

  keypad_emulator_if #(.DEPTH(DEPTH)) bus ();

  keypad_emulator #(
    .DEPTH          (DEPTH),
    .HOLD_MATCHES   (HOLD),
    .GAP_CYCLES     (GAP),
    .BOUNCE_MATCHES (BOUNCE)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic next_row();
    bus.keyrow = rows[rot];
    rot = (rot + 1) % 4;
  endtask

  task automatic idle_step(input logic [7:0] exp_level);
    next_row();
    @(negedge clock);
    chk("idle_busy", 8'(bus.busy), 8'd0);
    chk("idle_done", 8'(bus.done), 8'd0);
    chk("idle_keycol", 8'(bus.keycol), 8'h0F);
    chk("idle_level", 8'(bus.level), exp_level);
    tick();
  endtask

  // Entered just after the edge that popped the key; rotates rows until the
  // key has seen all its matches, then checks the full gap.
  task automatic run_key(input logic [3:0] row, input logic [3:0] col,
                         input bit do_push, input logic [3:0] pcode);
    int unsigned m;
    int unsigned total;
    bit first;
    logic [3:0] exp;
    m = 0;
    first = 1'b1;
    total = HOLD;
`ifdef KEYPAD_EMU_BOUNCE_EN
    total = total + BOUNCE;
`endif
    while (m < total) begin
      next_row();
      if (first && do_push) begin
        bus.key_valid = 1'b1;
        bus.key_code  = pcode;
      end
      @(negedge clock);
      exp = 4'hF;
      if (bus.keyrow == row) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
        if (m < BOUNCE) exp = (m % 2 == 1) ? col : 4'hF;
        else exp = col;
`else
        exp = col;
`endif
        m++;
      end
      chk("press_keycol", 8'(bus.keycol), 8'(exp));
      chk("press_busy", 8'(bus.busy), 8'd1);
      chk("press_done", 8'(bus.done), 8'd0);
      if (first && do_push) chk("press_push_ready", 8'(bus.key_ready), 8'd1);
      tick();
      bus.key_valid = 1'b0;
      first = 1'b0;
    end
    for (int g = 0; g < int'(GAP); g++) begin
      next_row();
      @(negedge clock);
      chk("gap_keycol", 8'(bus.keycol), 8'h0F);
      chk("gap_busy", 8'(bus.busy), 8'd1);
      chk("gap_done", 8'(bus.done), (g == int'(GAP) - 1) ? 8'd1 : 8'd0);
      tick();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rot         = 0;
    rows[0] = 4'b0111; rows[1] = 4'b1011; rows[2] = 4'b1101; rows[3] = 4'b1110;
    burst[0] = 4'hC; burst[1] = 4'h0; burst[2] = 4'hF; burst[3] = 4'h9;
    reset         = 1'b0;
    bus.keyrow    = 4'hF;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;

    // Reset values
    tick();
    tick();
    @(negedge clock);
    chk("rst_keycol", 8'(bus.keycol), 8'h0F);
    chk("rst_ready", 8'(bus.key_ready), 8'd1);
    chk("rst_level", 8'(bus.level), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_done", 8'(bus.done), 8'd0);
    reset = 1'b1;
    tick();

    // Idle row rotation
    repeat (4) begin
      next_row();
      @(negedge clock);
      chk("rot_keycol", 8'(bus.keycol), 8'h0F);
      chk("rot_ready", 8'(bus.key_ready), 8'd1);
      chk("rot_level", 8'(bus.level), 8'd0);
      tick();
    end

    // Single key 0x5
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h5;
    next_row();
    @(negedge clock);
    chk("k5_ready", 8'(bus.key_ready), 8'd1);
    tick();
    bus.key_valid = 1'b0;
    idle_step(8'd1);
    run_key(4'b1101, 4'b1101, 1'b0, 4'h0);
    idle_step(8'd0);

    // Key 0x1 with scanner stuck on row 0111, FIFO filled meanwhile
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h1;
    tick();
    bus.key_valid = 1'b0;
    idle_step(8'd1);
    bus.keyrow = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      bus.key_valid = 1'b1;
      bus.key_code  = burst[i];
      @(negedge clock);
      chk("stuck_keycol", 8'(bus.keycol), 8'h0F);
      chk("stuck_busy", 8'(bus.busy), 8'd1);
      chk("stuck_ready", 8'(bus.key_ready), 8'd1);
      tick();
    end
    bus.key_code = 4'h3;
    repeat (3) begin
      @(negedge clock);
      chk("full_ready", 8'(bus.key_ready), 8'd0);
      chk("full_level", 8'(bus.level), 8'd4);
      chk("full_keycol", 8'(bus.keycol), 8'h0F);
      chk("full_busy", 8'(bus.busy), 8'd1);
      tick();
    end
    bus.key_valid = 1'b0;
    run_key(4'b1110, 4'b1011, 1'b0, 4'h0);

    // Queued keys C,0,F,9 then stalled 0x3 pushed once C is popped
    idle_step(8'd4);
    run_key(4'b0111, 4'b1110, 1'b1, 4'h3);
    idle_step(8'd4);
    run_key(4'b1110, 4'b0111, 1'b0, 4'h0);
    idle_step(8'd3);
    run_key(4'b0111, 4'b0111, 1'b0, 4'h0);
    idle_step(8'd2);
    run_key(4'b1011, 4'b1110, 1'b0, 4'h0);
    idle_step(8'd1);
    run_key(4'b1011, 4'b1011, 1'b0, 4'h0);
    idle_step(8'd0);

    // Reset during press of 0xA with B and D queued
    bus.keyrow    = 4'b1110;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'hA;
    tick();
    bus.key_code = 4'hB;
    tick();
    bus.key_code = 4'hD;
    tick();
    bus.key_valid = 1'b0;
    bus.keyrow    = 4'b1101;
    @(negedge clock);
`ifdef KEYPAD_EMU_BOUNCE_EN
    chk("ka_keycol", 8'(bus.keycol), 8'h0F);
`else
    chk("ka_keycol", 8'(bus.keycol), 8'h07);
`endif
    chk("ka_busy", 8'(bus.busy), 8'd1);
    chk("ka_level", 8'(bus.level), 8'd2);
    reset = 1'b0;
    tick();
    @(negedge clock);
    chk("mrst_keycol", 8'(bus.keycol), 8'h0F);
    chk("mrst_level", 8'(bus.level), 8'd0);
    chk("mrst_busy", 8'(bus.busy), 8'd0);
    chk("mrst_done", 8'(bus.done), 8'd0);
    chk("mrst_ready", 8'(bus.key_ready), 8'd1);
    tick();
    reset = 1'b1;
    repeat (GAP + 8) begin
      next_row();
      @(negedge clock);
      chk("post_keycol", 8'(bus.keycol), 8'h0F);
      chk("post_done", 8'(bus.done), 8'd0);
      chk("post_busy", 8'(bus.busy), 8'd0);
      chk("post_level", 8'(bus.level), 8'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
